// File: rtl/run_detect_sched_pkg.sv
// -----------------------------------------------------------------------------
// run_detect_sched_pkg
// Shared definitions for the run-length detector scheduler.
//   state_t         : scheduler FSM state encoding (3 bits)
//   DEF_NREQ        : default number of requesters
//   DEF_WORD_W      : default bits per job word
//   DEF_RUN_LEN     : default run length that raises detection
//   DEF_CNT_W       : default hit counter width
// -----------------------------------------------------------------------------
package run_detect_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TAIL  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_NREQ    = 2;
    localparam int DEF_WORD_W  = 8;
    localparam int DEF_RUN_LEN = 4;
    localparam int DEF_CNT_W   = 4;

endpackage

// File: rtl/run_detect_sched_detector.sv
// -----------------------------------------------------------------------------
// run_detector
// Run-length sequence detector: raises z while the current run of equal bits
// is at least RUN_LEN long. The run counter saturates at RUN_LEN, so
// overlapping runs keep z high on every further equal bit.
//   i_clk  : system clock, rising edge
//   i_rst  : synchronous active-high reset
//   i_clr  : synchronous clear (start of a new job)
//   i_en   : consume i_w at the end of this cycle
//   i_w    : serial input bit
//   o_z    : registered (Moore) detection output
// -----------------------------------------------------------------------------
module run_detector
    import run_detect_sched_pkg::*;
#(
    parameter int RUN_LEN = DEF_RUN_LEN
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_w,
    output logic o_z
);

    localparam int RW = $clog2(RUN_LEN + 1);

    logic [RW-1:0] r_run;
    logic [RW-1:0] w_run_next;
    logic          r_last;
    logic          r_z;

    // A run length of zero marks "nothing seen since clear", so the first bit
    // always starts a fresh run of 1 regardless of the stale last-bit value.
    always_comb begin
        w_run_next = r_run;
        if (r_run == '0 || i_w != r_last) begin
            w_run_next = RW'(1);
        end else if (r_run != RW'(RUN_LEN)) begin
            w_run_next = r_run + RW'(1);
        end
    end

    // Clear and reset both drop the run so nothing carries across jobs.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_run  <= '0;
            r_last <= 1'b0;
            r_z    <= 1'b0;
        end else if (i_en) begin
            r_run  <= w_run_next;
            r_last <= i_w;
            r_z    <= (w_run_next == RW'(RUN_LEN));
        end
    end

    assign o_z = r_z;

endmodule

// File: rtl/run_detect_sched.sv
// -----------------------------------------------------------------------------
// run_detect_sched
// Round-robin scheduler sharing one run_detector among NREQ requesters. A
// granted word is shifted MSB-first through the detector and the number of
// detections is reported with a one-cycle done pulse.
//   i_clk        : system clock, rising edge
//   i_rst        : synchronous active-high reset
//   i_req        : per-requester request, held with data until grant
//   i_data       : requester i word at [i*WORD_W +: WORD_W]
//   o_grant      : one-hot pulse while the granted word is captured
//   o_busy       : high in every state except IDLE
//   o_w_out      : bit currently presented to the detector
//   o_z_out      : detector output
//   o_done       : one-cycle pulse at job end
//   o_done_id    : ID of the completed job, held until next LOAD
//   o_hit_count  : detections in the completed job, held until next LOAD
// -----------------------------------------------------------------------------
module run_detect_sched
    import run_detect_sched_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int WORD_W  = DEF_WORD_W,
    parameter int RUN_LEN = DEF_RUN_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ*WORD_W-1:0]   i_data,
    output logic [NREQ-1:0]          o_grant,
    output logic                     o_busy,
    output logic                     o_w_out,
    output logic                     o_z_out,
    output logic                     o_done,
    output logic [IDW-1:0]           o_done_id,
    output logic [CNT_W-1:0]         o_hit_count
);

    localparam int KW = $clog2(WORD_W);

    state_t              r_state;
    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      r_sel;
    logic [WORD_W-1:0]   r_word;
    logic [KW-1:0]       r_k;
    logic [NREQ-1:0]     r_grant;
    logic                r_done;
    logic [IDW-1:0]      r_done_id;
    logic [CNT_W-1:0]    r_hit;

    logic                w_found;
    logic [IDW-1:0]      w_sel;
    logic [IDW-1:0]      w_cand;
    logic                w_z;
    logic                w_det_clr;
    logic                w_det_en;
    logic                w_count;

    // Scan requesters starting at the pointer and wrapping; the first one
    // found wins, which gives strict round-robin once the pointer advances
    // past each served requester.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = IDW'((int'(r_ptr) + i) % NREQ);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    // z_out lags the consumed bit by one cycle, so SHIFT k=0 still shows the
    // cleared detector and TAIL shows the result of the last bit.
    assign w_count = w_z && (r_hit != '1) &&
                     ((r_state == ST_TAIL) || (r_state == ST_SHIFT && r_k != '0));

    // Main sequencer. The word is kept in a shift register whose MSB drives
    // the detector; the final shift is skipped so w_out holds through TAIL.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_word    <= '0;
            r_k       <= '0;
            r_grant   <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_hit     <= '0;
        end else begin
            r_grant <= '0;
            r_done  <= 1'b0;
            if (w_count) begin
                r_hit <= r_hit + CNT_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_sel   <= w_sel;
                        r_grant <= NREQ'(1) << w_sel;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_word  <= i_data[int'(r_sel)*WORD_W +: WORD_W];
                    r_hit   <= '0;
                    r_k     <= '0;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (r_k == KW'(WORD_W - 1)) begin
                        r_state <= ST_TAIL;
                    end else begin
                        r_k    <= r_k + KW'(1);
                        r_word <= r_word << 1;
                    end
                end
                ST_TAIL: begin
                    r_done    <= 1'b1;
                    r_done_id <= r_sel;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    r_ptr   <= (r_sel == IDW'(NREQ - 1)) ? '0 : r_sel + IDW'(1);
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_det_clr = (r_state == ST_LOAD);
    assign w_det_en  = (r_state == ST_SHIFT);

    run_detector #(
        .RUN_LEN (RUN_LEN)
    ) u_det (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_det_clr),
        .i_en  (w_det_en),
        .i_w   (o_w_out),
        .o_z   (w_z)
    );

    assign o_grant     = r_grant;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_w_out     = r_word[WORD_W-1];
    assign o_z_out     = w_z;
    assign o_done      = r_done;
    assign o_done_id   = r_done_id;
    assign o_hit_count = r_hit;

endmodule

// File: tb/tb_run_detect_sched.sv
// -----------------------------------------------------------------------------
// tb_run_detect_sched
// Directed bench for run_detect_sched: a default-parameter instance plus a
// CNT_W=2 instance to exercise hit counter saturation.
// -----------------------------------------------------------------------------
module tb_run_detect_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] data;
    logic [1:0]  grant;
    logic        busy, wOut, zOut, done;
    logic        doneId;
    logic [3:0]  hitCount;

    logic [1:0]  reqS;
    logic [15:0] dataS;
    logic [1:0]  grantS;
    logic        busyS, wOutS, zOutS, doneS;
    logic        doneIdS;
    logic [1:0]  hitCountS;

    int cyc        = 0;
    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    run_detect_sched dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_data      (data),
        .o_grant     (grant),
        .o_busy      (busy),
        .o_w_out     (wOut),
        .o_z_out     (zOut),
        .o_done      (done),
        .o_done_id   (doneId),
        .o_hit_count (hitCount)
    );

    run_detect_sched #(.CNT_W(2)) dutSat (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (reqS),
        .i_data      (dataS),
        .o_grant     (grantS),
        .o_busy      (busyS),
        .o_w_out     (wOutS),
        .o_z_out     (zOutS),
        .o_done      (doneS),
        .o_done_id   (doneIdS),
        .o_hit_count (hitCountS)
    );

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [15:0] d);
        req  = r;
        data = d;
    endtask

    // Runs one job from IDLE for a single requester and checks grant,
    // first bit, latency, result and the one-cycle done pulse.
    task automatic doJob(input int id, input logic [7:0] word, input int expHits);
        logic [1:0]  r;
        logic [15:0] d;
        int          gc;
        bit          seen;
        r = '0;
        r[id] = 1'b1;
        d = data;
        d[id*8 +: 8] = word;
        applyStimulus(r, d);
        tick();
        checkOutput("job_grant", grant, r);
        gc = cyc;
        applyStimulus(2'b00, d);
        tick();
        checkOutput("job_w_out_k0", wOut, word[7]);
        checkOutput("job_busy", busy, 1);
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (done) seen = 1;
        end
        checkOutput("job_done_seen", seen, 1);
        checkOutput("job_latency", cyc - gc, 10);
        checkOutput("job_done_id", doneId, id);
        checkOutput("job_hit_count", hitCount, expHits);
        tick();
        checkOutput("job_done_pulse", done, 0);
        checkOutput("job_busy_after", busy, 0);
        checkOutput("job_hit_held", hitCount, expHits);
    endtask

    initial begin
        int  gc;
        int  prevDone;
        bit  seen;

        rst   = 1'b1;
        reqS  = 2'b00;
        dataS = 16'h0000;
        prevDone = 0;
        applyStimulus(2'b11, 16'h00F0);

        // Reset held two cycles with both requests high.
        tick();
        tick();
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_done_id", doneId, 0);
        checkOutput("rst_hit", hitCount, 0);
        checkOutput("rst_w_out", wOut, 0);
        checkOutput("rst_z_out", zOut, 0);

        // Release: requester 0 is granted one cycle later; its word F0 gives 2.
        rst = 1'b0;
        tick();
        checkOutput("first_grant", grant, 2'b01);
        gc = cyc;
        applyStimulus(2'b00, 16'h00F0);
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (done) seen = 1;
        end
        checkOutput("first_done_seen", seen, 1);
        checkOutput("first_latency", cyc - gc, 10);
        checkOutput("first_done_id", doneId, 0);
        checkOutput("first_hit", hitCount, 2);
        tick();

        // Overlapping runs, no runs, trailing short run.
        doJob(0, 8'hFF, 5);
        doJob(0, 8'hAA, 0);
        doJob(1, 8'h07, 2);

        // Both requesting continuously: pointer now 0, so grants go 0,1,0,1.
        applyStimulus(2'b11, 16'h0FFF);
        for (int j = 0; j < 4; j++) begin
            seen = 0;
            for (int n = 0; n < 20 && !seen; n++) begin
                tick();
                if (grant != 2'b00) seen = 1;
            end
            checkOutput("rr_grant", grant, (j % 2 == 0) ? 2'b01 : 2'b10);
            seen = 0;
            for (int n = 0; n < 20 && !seen; n++) begin
                tick();
                if (done) seen = 1;
            end
            checkOutput("rr_done_seen", seen, 1);
            checkOutput("rr_done_id", doneId, j % 2);
            checkOutput("rr_hit", hitCount, (j % 2 == 0) ? 5 : 2);
            if (j > 0) checkOutput("rr_spacing", cyc - prevDone, 12);
            prevDone = cyc;
        end
        applyStimulus(2'b00, 16'h0FFF);
        tick();
        tick();
        checkOutput("rr_idle_busy", busy, 0);

        // Reset during SHIFT k=3 discards the job.
        applyStimulus(2'b10, 16'hFF00);
        tick();
        checkOutput("mid_grant", grant, 2'b10);
        applyStimulus(2'b00, 16'hFF00);
        tick();
        tick();
        tick();
        tick();
        checkOutput("mid_busy_k3", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_busy_after_rst", busy, 0);
        checkOutput("mid_hit_after_rst", hitCount, 0);
        checkOutput("mid_z_after_rst", zOut, 0);
        seen = 0;
        for (int n = 0; n < 15; n++) begin
            tick();
            if (done) seen = 1;
        end
        checkOutput("mid_no_done", seen, 0);
        doJob(1, 8'hE0, 2);

        // Saturating counter instance: FF would give 5, clipped to 3.
        reqS  = 2'b01;
        dataS = 16'h00FF;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (grantS != 2'b00) seen = 1;
        end
        checkOutput("sat_grant", grantS, 2'b01);
        reqS = 2'b00;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (doneS) seen = 1;
        end
        checkOutput("sat_done_seen", seen, 1);
        checkOutput("sat_hit", hitCountS, 3);
        checkOutput("sat_done_id", doneIdS, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
